// File: rtl/lock_on_reset_bank.sv
// Bank of CHANNELS write-protected registers. The bank comes out of reset locked,
// opens only after a two-word key sequence, and counts every illegal access.
module lock_on_reset_bank #(
    parameter int unsigned        WIDTH     = 8,
    parameter int unsigned        CHANNELS  = 4,
    parameter int unsigned        KEY_W     = 16,
    parameter logic [KEY_W-1:0]   KEY0      = 16'hA5C3,
    parameter logic [KEY_W-1:0]   KEY1      = 16'h3C5A,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int unsigned        CNT_W     = 4,
    localparam int unsigned       CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        wr_en,
    input  logic [CH_W-1:0]             wr_ch,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        unlock_req,
    input  logic [KEY_W-1:0]            key_in,
    input  logic                        lock_req,
    input  logic                        sticky_lock_req,
    output logic [CHANNELS*WIDTH-1:0]   data_out,
    output logic                        unlocked,
    output logic                        sticky,
    output logic                        viol_pulse,
    output logic [CNT_W-1:0]            viol_count
);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_ARMED    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_STICKY   = 2'd3
    } state_e;

    state_e                             state_q;
    logic                               unlocked_q;
    logic                               sticky_q;
    logic                               viol_pulse_q;
    logic [CNT_W-1:0]                   viol_count_q;
    logic [CHANNELS-1:0][WIDTH-1:0]     regs_q;

    logic ch_valid;
    logic wr_accept;
    logic wr_reject;
    logic key_fail;
    logic viol_d;

    // Access decode uses the state before the edge, so a write racing a lock still lands.
    always_comb begin
        ch_valid  = 32'(wr_ch) < CHANNELS;
        wr_accept = wr_en && (state_q == ST_UNLOCKED) && ch_valid;
        wr_reject = wr_en && !wr_accept;
        key_fail  = 1'b0;
        if (unlock_req && !sticky_lock_req && !lock_req) begin
            if (state_q == ST_LOCKED && key_in != KEY0) key_fail = 1'b1;
            if (state_q == ST_ARMED  && key_in != KEY1) key_fail = 1'b1;
        end
        viol_d = wr_reject || key_fail;
    end

    // Lock FSM; sticky beats lock beats unlock, and STICKY only leaves via reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_LOCKED;
            unlocked_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else if (sticky_lock_req || state_q == ST_STICKY) begin
            state_q    <= ST_STICKY;
            unlocked_q <= 1'b0;
            sticky_q   <= 1'b1;
        end else if (lock_req) begin
            state_q    <= ST_LOCKED;
            unlocked_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_LOCKED: begin
                    if (unlock_req && key_in == KEY0) state_q <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (unlock_req && key_in == KEY1) begin
                        state_q    <= ST_UNLOCKED;
                        unlocked_q <= 1'b1;
                    end else begin
                        state_q    <= ST_LOCKED;
                    end
                end
                default: ;
            endcase
        end
    end

    // Channel storage: only an accepted write touches it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < CHANNELS; i++) regs_q[i] <= RESET_VAL;
        end else if (wr_accept) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (wr_ch == CH_W'(i)) regs_q[i] <= wr_data;
            end
        end
    end

    // Violation pulse and saturating counter; simultaneous causes count once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            viol_pulse_q <= 1'b0;
            viol_count_q <= '0;
        end else begin
            viol_pulse_q <= viol_d;
            if (viol_d && viol_count_q != {CNT_W{1'b1}}) begin
                viol_count_q <= viol_count_q + CNT_W'(1);
            end
        end
    end

    assign data_out   = regs_q;
    assign unlocked   = unlocked_q;
    assign sticky     = sticky_q;
    assign viol_pulse = viol_pulse_q;
    assign viol_count = viol_count_q;

endmodule

// File: tb/tb_lock_on_reset_bank.sv
// Scoreboard bench for lock_on_reset_bank (3-channel build so wr_ch=3 is out of range).
module tb_lock_on_reset_bank;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned CH_W     = 2;
    localparam int unsigned CNT_W    = 4;
    localparam logic [15:0] K0       = 16'hA5C3;
    localparam logic [15:0] K1       = 16'h3C5A;

    localparam int M_LOCKED   = 0;
    localparam int M_ARMED    = 1;
    localparam int M_UNLOCKED = 2;
    localparam int M_STICKY   = 3;

    typedef struct packed {
        logic [CHANNELS*WIDTH-1:0] data;
        logic                      unl;
        logic                      stk;
        logic                      vp;
        logic [CNT_W-1:0]          vc;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        resetn;
    logic                        wr_en;
    logic [CH_W-1:0]             wr_ch;
    logic [WIDTH-1:0]            wr_data;
    logic                        unlock_req;
    logic [15:0]                 key_in;
    logic                        lock_req;
    logic                        sticky_lock_req;
    logic [CHANNELS*WIDTH-1:0]   data_out;
    logic                        unlocked;
    logic                        sticky;
    logic                        viol_pulse;
    logic [CNT_W-1:0]            viol_count;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          m_state;
    logic [7:0]  m_regs [CHANNELS];
    logic [3:0]  m_vc;

    lock_on_reset_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .KEY_W    (16),
        .KEY0     (K0),
        .KEY1     (K1),
        .RESET_VAL(8'h00),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wr_en          (wr_en),
        .wr_ch          (wr_ch),
        .wr_data        (wr_data),
        .unlock_req     (unlock_req),
        .key_in         (key_in),
        .lock_req       (lock_req),
        .sticky_lock_req(sticky_lock_req),
        .data_out       (data_out),
        .unlocked       (unlocked),
        .sticky         (sticky),
        .viol_pulse     (viol_pulse),
        .viol_count     (viol_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_LOCKED;
        m_vc    = 4'h0;
        for (int i = 0; i < CHANNELS; i++) m_regs[i] = 8'h00;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        unlock_req = 1'b0; key_in = '0; lock_req = 1'b0; sticky_lock_req = 1'b0;
    endtask

    // Drive one cycle, predict its outcome, then compare after the edge.
    task automatic step(input logic we, input logic [1:0] ch, input logic [7:0] d,
                        input logic ur, input logic [15:0] k,
                        input logic lr, input logic slr);
        logic viol;
        logic wok;
        int   ns;
        exp_t e;
        wr_en = we; wr_ch = ch; wr_data = d;
        unlock_req = ur; key_in = k; lock_req = lr; sticky_lock_req = slr;

        viol = 1'b0;
        wok  = we && (m_state == M_UNLOCKED) && (int'(ch) < CHANNELS);
        if (we && !wok) viol = 1'b1;
        if (ur && !slr && !lr) begin
            if (m_state == M_LOCKED && k != K0) viol = 1'b1;
            if (m_state == M_ARMED  && k != K1) viol = 1'b1;
        end
        ns = m_state;
        if (m_state == M_STICKY || slr)      ns = M_STICKY;
        else if (lr)                         ns = M_LOCKED;
        else if (m_state == M_LOCKED)        ns = (ur && k == K0) ? M_ARMED : M_LOCKED;
        else if (m_state == M_ARMED)         ns = (ur && k == K1) ? M_UNLOCKED : M_LOCKED;
        m_state = ns;
        if (wok) m_regs[ch] = d;
        if (viol && m_vc != 4'hF) m_vc = m_vc + 4'h1;

        e.data = {m_regs[2], m_regs[1], m_regs[0]};
        e.unl  = (m_state == M_UNLOCKED);
        e.stk  = (m_state == M_STICKY);
        e.vp   = viol;
        e.vc   = m_vc;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        check_val("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val("data_out",   32'(data_out),   32'(e.data));
            check_val("unlocked",   32'(unlocked),   32'(e.unl));
            check_val("sticky",     32'(sticky),     32'(e.stk));
            check_val("viol_pulse", 32'(viol_pulse), 32'(e.vp));
            check_val("viol_count", 32'(viol_count), 32'(e.vc));
        end
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_data"},   32'(data_out),   32'd0);
        check_val({tag, "_unl"},    32'(unlocked),   32'd0);
        check_val({tag, "_stk"},    32'(sticky),     32'd0);
        check_val({tag, "_vp"},     32'(viol_pulse), 32'd0);
        check_val({tag, "_vc"},     32'(viol_count), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        resetn = 1'b0;
        #1;
        check_cleared("reset");
        model_reset();
        sb_q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic unlock_seq();
        step(1'b0, 2'd0, 8'h00, 1'b1, K0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b1, K1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rk;
        idle_inputs();
        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Write while locked is rejected
        do_reset();
        step(1'b1, 2'd0, 8'h5A, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 16'h0, 1'b0, 1'b0);

        // Unlock, write, relock, rejected write
        do_reset();
        unlock_seq();
        step(1'b1, 2'd2, 8'hC3, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b1, 2'd2, 8'h00, 1'b0, 16'h0, 1'b0, 1'b0);

        // Broken sequence: idle cycle between keys
        do_reset();
        step(1'b0, 2'd0, 8'h00, 1'b1, K0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b1, K1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0);

        // Sticky with coincident write, then unlock attempts are ignored
        do_reset();
        unlock_seq();
        step(1'b1, 2'd1, 8'h11, 1'b0, 16'h0, 1'b0, 1'b1);
        unlock_seq();
        step(1'b1, 2'd0, 8'h77, 1'b0, 16'h0, 1'b1, 1'b0);
        do_reset();

        // Out-of-range channel and counter saturation
        do_reset();
        unlock_seq();
        step(1'b1, 2'd0, 8'h3C, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 2'd3, 8'hEE, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 2'd3, 8'(i), 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 8'h96, 1'b0, 16'h0, 1'b0, 1'b0);
        check_val("sat_count", 32'(viol_count), 32'hF);

        // Async reset while ARMED with a write pending
        do_reset();
        step(1'b0, 2'd0, 8'h00, 1'b1, K0, 1'b0, 1'b0);
        wr_en = 1'b1; wr_ch = 2'd0; wr_data = 8'hAA;
        unlock_req = 1'b1; key_in = K1;
        #3;
        resetn = 1'b0;
        #1;
        check_cleared("async");
        model_reset();
        sb_q.delete();
        idle_inputs();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step(1'b0, 2'd0, 8'h00, 1'b1, K1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 16'h0, 1'b0, 1'b0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 2))
                0:       rk = K0;
                1:       rk = K1;
                default: rk = 16'($urandom);
            endcase
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), rk,
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lock_on_reset_bank.md
Name: lock_on_reset_bank

Overview:
Multi-channel, parametrised successor to the single-bit lock-on-reset register. It holds CHANNELS registers of WIDTH bits and comes out of reset locked. Writes are accepted only after a two-step key unlock sequence. An optional sticky lock can only be cleared by reset. Illegal write attempts are flagged and counted, so the block can sit in front of security-critical configuration fields.

Parameters:
WIDTH, 8, bit width of each channel register
CHANNELS, 4, number of channel registers (>=1)
KEY_W, 16, width of key_in
KEY0, 16'hA5C3, first unlock key word
KEY1, 16'h3C5A, second unlock key word
RESET_VAL, 0, reset value of every channel register (WIDTH bits)
CNT_W, 4, width of the saturating violation counter
CH_W (derived, not overridable), max(1, $clog2(CHANNELS)), width of wr_ch

Ports:
clk  input  1  clock; all state changes on rising edge
resetn  input  1  asynchronous, active-low reset
wr_en  input  1  write request for this cycle
wr_ch  input  CH_W  target channel index
wr_data  input  WIDTH  write data
unlock_req  input  1  unlock-sequence step strobe; key_in sampled with it
key_in  input  KEY_W  key word
lock_req  input  1  return to LOCKED
sticky_lock_req  input  1  enter STICKY; only reset exits
data_out  output  CHANNELS*WIDTH  all channel registers; channel i is at [i*WIDTH +: WIDTH]
unlocked  output  1  high in UNLOCKED state
sticky  output  1  high in STICKY state
viol_pulse  output  1  one-cycle flag for a rejected write or a failed key step
viol_count  output  CNT_W  saturating count of violations

Behaviour:
- Reset (resetn=0, asynchronous): all channels = RESET_VAL; state = LOCKED; unlocked=0, sticky=0, viol_pulse=0, viol_count=0. Reset asserted mid-sequence or mid-write aborts immediately; no partial update.
- States: LOCKED, ARMED, UNLOCKED, STICKY. Outputs are registered and decoded from state: unlocked = (state==UNLOCKED), sticky = (state==STICKY).
- Transition priority per cycle: sticky_lock_req > lock_req > unlock_req.
- STICKY: entered from any state when sticky_lock_req=1; exited only by reset. All other requests are ignored.
- lock_req=1, not sticky: next state LOCKED, from any of LOCKED, ARMED or UNLOCKED.
- LOCKED, unlock_req=1:
  - key_in==KEY0 -> ARMED.
  - otherwise stay LOCKED and flag a violation.
- ARMED: the very next cycle decides.
  - unlock_req=1 and key_in==KEY1 -> UNLOCKED.
  - any other input (including no unlock_req) -> LOCKED; this counts as a violation only if unlock_req=1.
- UNLOCKED, unlock_req=1: ignored; no state change, no violation.
- Writes:
  - Accepted iff the current state (before the edge) is UNLOCKED and wr_ch < CHANNELS.
  - The selected channel takes wr_data at that edge; data_out reflects it in the following cycle (1-cycle latency).
  - A write in the same cycle as lock_req or sticky_lock_req is still accepted, because the decision uses the current state.
- Rejected write: wr_en=1 while not UNLOCKED, or wr_ch >= CHANNELS. No register changes; violation flagged.
- Violation handling:
  - viol_pulse=1 in the cycle after the offending input, for exactly one cycle.
  - viol_count increments by 1 and saturates at 2^CNT_W-1; it never wraps.
  - A rejected write and a failed key step in the same cycle count once.
- Only a write changes a channel register. Lock, sticky and state transitions never alter stored data.

Test Plan:
- Reset, then wr_en=1, wr_ch=0, wr_data=8'h5A -> data_out ch0 stays 8'h00, viol_pulse=1 for one cycle, viol_count=1.
- unlock_req with KEY0 then KEY1 on consecutive cycles -> unlocked=1 on the second following edge. Write ch2=8'hC3 -> ch2=8'hC3 one cycle later. Then lock_req -> unlocked=0; write ch2=8'h00 -> ch2 stays 8'hC3, viol_count=1.
- KEY0, then an idle cycle, then KEY1 -> state LOCKED, unlocked=0. The KEY1 step counts as a violation because it arrives in LOCKED and does not match KEY0.
- While UNLOCKED: sticky_lock_req together with a write of ch1=8'h11 -> ch1=8'h11 and sticky=1. A subsequent KEY0/KEY1 sequence -> sticky stays 1, unlocked stays 0. Pulse resetn=0 -> all channels 8'h00, sticky=0.
- While UNLOCKED, CHANNELS=3: write wr_ch=3 -> no channel changes, viol_pulse=1. Then 20 rejected writes -> viol_count saturates at 4'hF.
- Assert resetn=0 asynchronously between clock edges while ARMED with a write pending -> outputs clear immediately; the next KEY1 alone does not unlock.
